// File: rtl/fw_mem_responder.sv
// Firmware-SRAM read responder for the crypto engine's mem_* port.
// Shares the SRAM with the CPU: the CPU wins arbitration until starvation forces a stall.
module fw_mem_responder #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE    = 32'h0001_0000,
  parameter int          RD_LATENCY   = 1,
  parameter int          STARVE_LIMIT = 4,
  localparam int         AW           = $clog2(ADDR_SIZE / 4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   req_addr,
  input  logic          req_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_ready,
  output logic          rsp_err,
  input  logic          cpu_busy,
  output logic          cpu_stall,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_rdata,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshake: req_valid is held with a stable address until the one-cycle
  // rsp_ready strobe; the initiator then drops req_valid for at least one
  // cycle before the next request. rsp_err qualifies rsp_ready.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] LAT_LAST  = 2'(RD_LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t        r_state;
  logic [AW-1:0] r_word;
  logic [1:0]    r_lat_cnt;
  logic [3:0]    r_starve;

  logic [32:0]   w_off;
  logic          w_addr_ok;
  logic [3:0]    w_starve_inc;

  // The 33rd bit catches addresses below the base and wrap-around.
  assign w_off        = {1'b0, req_addr} - {1'b0, ADDR_BASE};
  assign w_addr_ok    = (req_addr[1:0] == 2'b00) && !w_off[32] && (w_off[31:0] < ADDR_SIZE);
  assign w_starve_inc = (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;

  // An aborting request must not issue a read in its final ARB cycle.
  assign sram_en   = (r_state == S_ARB) && req_valid && !cpu_busy;
  assign sram_addr = r_word;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_lat_cnt <= '0;
      r_starve  <= '0;
      rsp_rdata <= '0;
      rsp_ready <= 1'b0;
      rsp_err   <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word <= w_off[AW+1:2];
            if (w_addr_ok) begin
              r_state <= S_ARB;
            end else begin
              r_state   <= S_ERR;
              rsp_ready <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        S_ARB: begin
          if (!req_valid) begin
            r_state   <= S_IDLE;
            r_starve  <= '0;
            cpu_stall <= 1'b0;
          end else if (!cpu_busy) begin
            r_state   <= S_WAIT;
            r_lat_cnt <= '0;
            r_starve  <= '0;
            cpu_stall <= 1'b0;
          end else begin
            r_starve <= w_starve_inc;
            if (w_starve_inc >= STARVE_LIM) cpu_stall <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_lat_cnt <= '0;
            if (req_valid) begin
              r_state   <= S_RESP;
              rsp_rdata <= sram_rdata;
              rsp_ready <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        S_RESP: begin
          rsp_ready <= 1'b0;
          r_state   <= S_DONE;
        end
        S_ERR: begin
          rsp_ready <= 1'b0;
          rsp_err   <= 1'b0;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (!req_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_mem_responder.sv
// Bench for fw_mem_responder: instance A (latency 1) under random and directed
// traffic with a scoreboard; instance B (latency 4) for latency and reset mid-WAIT.
module tb_fw_mem_responder;

  localparam logic [31:0] BASE_A   = 32'h0000_0000;
  localparam logic [31:0] SIZE_A   = 32'h0001_0000;
  localparam int          LAT_A    = 1;
  localparam int          STARVE_A = 4;
  localparam int          NWORDS   = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem [NWORDS];

  // Instance A
  logic        rst_n_a, req_valid_a, rsp_ready_a, rsp_err_a, cpu_busy_a, cpu_stall_a, sram_en_a, busy_a;
  logic [31:0] req_addr_a, rsp_rdata_a, sram_rdata_a;
  logic [13:0] sram_addr_a;
  logic [2:0]  dbg_state_a;

  fw_mem_responder #(.ADDR_BASE(BASE_A), .ADDR_SIZE(SIZE_A), .RD_LATENCY(LAT_A), .STARVE_LIMIT(STARVE_A)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_addr(req_addr_a), .req_valid(req_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_ready(rsp_ready_a), .rsp_err(rsp_err_a),
    .cpu_busy(cpu_busy_a), .cpu_stall(cpu_stall_a), .sram_en(sram_en_a),
    .sram_addr(sram_addr_a), .sram_rdata(sram_rdata_a), .busy(busy_a), .dbg_state(dbg_state_a));

  // Instance B
  logic        rst_n_b, req_valid_b, rsp_ready_b, rsp_err_b, cpu_busy_b, cpu_stall_b, sram_en_b, busy_b;
  logic [31:0] req_addr_b, rsp_rdata_b, sram_rdata_b;
  logic [13:0] sram_addr_b;
  logic [2:0]  dbg_state_b;

  fw_mem_responder #(.ADDR_BASE(BASE_A), .ADDR_SIZE(SIZE_A), .RD_LATENCY(4), .STARVE_LIMIT(STARVE_A)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_addr(req_addr_b), .req_valid(req_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_ready(rsp_ready_b), .rsp_err(rsp_err_b),
    .cpu_busy(cpu_busy_b), .cpu_stall(cpu_stall_b), .sram_en(sram_en_b),
    .sram_addr(sram_addr_b), .sram_rdata(sram_rdata_b), .busy(busy_b), .dbg_state(dbg_state_b));

  // SRAM models: data appears N cycles after the enable edge, garbage otherwise.
  always @(posedge clk) sram_rdata_a <= sram_en_a ? mem[sram_addr_a] : 32'hBAD0_BAD0;

  logic [31:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_b[0] <= sram_en_b ? mem[sram_addr_b] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_b[3] <= pipe_b[2];
  end
  assign sram_rdata_b = pipe_b[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: window membership with wide signed arithmetic.
  function automatic logic model_ok(input logic [31:0] a);
    longint a64, b64, off;
    a64 = 0; b64 = 0;
    a64[31:0] = a;
    b64[31:0] = BASE_A;
    off = a64 - b64;
    return (a64 % 4 == 0) && (off >= 0) && (off < longint'(SIZE_A));
  endfunction

  function automatic int word_index(input logic [31:0] a);
    return int'((a - BASE_A) / 4);
  endfunction

  // Monitor: pops one expectation per response strobe and checks the port invariant.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n_a) begin
      if (sram_en_a && cpu_busy_a) chk("sram_en_vs_cpu_busy", 32'(sram_en_a & cpu_busy_a), 32'd0);
      if (rsp_ready_a) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", 32'(rsp_err_a), 32'(e[32]));
          chk("rsp_rdata", rsp_rdata_a, e[31:0]);
        end
      end
    end
  end

  task automatic req_a(input logic [31:0] addr, input int nbusy, input int hold);
    logic ok;
    int k, exp_lat, widx;
    ok = model_ok(addr);
    widx = ok ? word_index(addr) : 0;
    exp_q.push_back(ok ? {1'b0, mem[widx]} : {1'b1, 32'h0});
    exp_lat = ok ? 2 + LAT_A + nbusy : 1;
    req_addr_a = addr;
    req_valid_a = 1'b1;
    cpu_busy_a = (nbusy > 0);
    tick();
    k = 0;
    while (!rsp_ready_a && k < 100) begin
      cpu_busy_a = (k < nbusy);
      #1;
      chk("sram_en", 32'(sram_en_a), 32'(k == nbusy));
      if (k == nbusy) chk("sram_addr", 32'(sram_addr_a), 32'(widx));
      chk("cpu_stall", 32'(cpu_stall_a), 32'(k >= STARVE_A && k <= nbusy));
      tick();
      k++;
    end
    chk("rsp_latency", 32'(k + 1), 32'(exp_lat));
    chk("sram_en_at_rsp", 32'(sram_en_a), 32'd0);
    cpu_busy_a = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("held_no_rsp", 32'(rsp_ready_a), 32'd0);
      chk("held_no_sram_en", 32'(sram_en_a), 32'd0);
    end
    req_valid_a = 1'b0;
    tick();
    tick();
    chk("busy_after_drop", 32'(busy_a), 32'd0);
  endtask

  task automatic abort_arb_a(input logic [31:0] addr);
    req_addr_a = addr;
    req_valid_a = 1'b1;
    cpu_busy_a = 1'b1;
    repeat (6) tick();
    chk("abort_arb_stall_up", 32'(cpu_stall_a), 32'd1);
    req_valid_a = 1'b0;
    tick();
    cpu_busy_a = 1'b0;
    chk("abort_arb_busy", 32'(busy_a), 32'd0);
    chk("abort_arb_stall_clr", 32'(cpu_stall_a), 32'd0);
    repeat (2) begin
      tick();
      chk("abort_arb_no_rsp", 32'(rsp_ready_a), 32'd0);
    end
  endtask

  task automatic abort_wait_a(input logic [31:0] addr);
    req_addr_a = addr;
    req_valid_a = 1'b1;
    cpu_busy_a = 1'b0;
    tick();
    tick();
    req_valid_a = 1'b0;
    tick();
    chk("abort_wait_no_rsp", 32'(rsp_ready_a), 32'd0);
    chk("abort_wait_busy", 32'(busy_a), 32'd0);
    tick();
    chk("abort_wait_no_rsp2", 32'(rsp_ready_a), 32'd0);
  endtask

  task automatic b_read(input logic [31:0] addr, output logic [31:0] data, output logic err, output int lat);
    req_addr_b = addr;
    req_valid_b = 1'b1;
    tick();
    lat = 1;
    while (!rsp_ready_b && lat < 30) begin
      tick();
      lat++;
    end
    data = rsp_rdata_b;
    err = rsp_err_b;
    req_valid_b = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return BASE_A + 32'($urandom_range(0, NWORDS - 1)) * 4;
    if (r == 7) return BASE_A + 32'($urandom_range(0, NWORDS - 1)) * 4 + 32'($urandom_range(1, 3));
    if (r == 8) return SIZE_A + 32'($urandom_range(0, 255)) * 4;
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_valid_a = 1'b0; req_addr_a = '0; cpu_busy_a = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; cpu_busy_b = 1'b0;
    repeat (3) tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
    chk("reset_rsp_rdata", rsp_rdata_a, 32'h0);
    chk("reset_rsp_ready", 32'(rsp_ready_a), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_a), 32'd0);
    chk("reset_cpu_stall", 32'(cpu_stall_a), 32'd0);
    chk("reset_sram_en", 32'(sram_en_a), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_state", 32'(dbg_state_a), 32'd0);

    // Directed: plain read, errors, starvation, saturation, held valid, aborts.
    req_a(32'h14, 0, 0);
    req_a(32'h0001_0000, 0, 0);
    req_a(32'h2, 0, 0);
    req_a(32'h40, 6, 0);
    req_a(32'h80, 18, 0);
    req_a(32'h100, 0, 5);
    abort_arb_a(32'h200);
    req_a(32'h200, 0, 0);
    abort_wait_a(32'h300);
    req_a(32'h300, 1, 0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) abort_arb_a(32'($urandom_range(0, NWORDS - 1)) * 4);
        else abort_wait_a(32'($urandom_range(0, NWORDS - 1)) * 4);
      end else begin
        req_a(rand_addr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0, $urandom_range(0, 2));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Instance B: latency 4, then reset in the middle of WAIT.
    b_read(32'h1C, d, e, lat);
    chk("b_latency", 32'(lat), 32'd6);
    chk("b_rdata", d, mem[7]);
    chk("b_err", 32'(e), 32'd0);
    req_addr_b = 32'hC;
    req_valid_b = 1'b1;
    repeat (3) tick();
    chk("b_in_wait", 32'(busy_b), 32'd1);
    rst_n_b = 1'b0;
    #1;
    chk("b_rst_rdata", rsp_rdata_b, 32'h0);
    chk("b_rst_ready", 32'(rsp_ready_b), 32'd0);
    chk("b_rst_err", 32'(rsp_err_b), 32'd0);
    chk("b_rst_stall", 32'(cpu_stall_b), 32'd0);
    chk("b_rst_sram_en", 32'(sram_en_b), 32'd0);
    chk("b_rst_busy", 32'(busy_b), 32'd0);
    req_valid_b = 1'b0;
    repeat (2) tick();
    rst_n_b = 1'b1;
    repeat (4) begin
      tick();
      chk("b_no_stale_rsp", 32'(rsp_ready_b), 32'd0);
    end
    b_read(32'h0, d, e, lat);
    chk("b_after_rst_latency", 32'(lat), 32'd6);
    chk("b_after_rst_rdata", d, mem[0]);
    chk("b_after_rst_err", 32'(e), 32'd0);
    chk("b_after_rst_busy", 32'(busy_b), 32'd0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fw_mem_responder.md
# fw_mem_responder

Memory-side responder for the crypto accelerator's firmware read port (`mem_addr`/`mem_valid`/`mem_rdata`/`mem_ready`). It services single-word read requests from the HMAC engine against the firmware SRAM. It shares the SRAM port with the CPU: the CPU normally has priority, and a starvation counter forces a CPU stall when needed. Requests that are out of range or misaligned get an error response without touching the SRAM.

## Interface
Parameters:
- `ADDR_BASE`, 32'h0000_0000, byte base address of the firmware window.
- `ADDR_SIZE`, 32'h0001_0000, window size in bytes; must be a power of two and ≥ 8.
- `RD_LATENCY`, 1, SRAM read latency in cycles; legal range 1..4.
- `STARVE_LIMIT`, 4, number of consecutive lost arbitration cycles before `cpu_stall` asserts; legal range 1..15.

Derived: `AW` = log2(`ADDR_SIZE`/4).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_addr`  in  32  byte address from the crypto `mem_addr`.
- `req_valid`  in  1  request from the crypto `mem_valid`; held with a stable address until `rsp_ready`.
- `rsp_rdata`  out  32  read data to the crypto `mem_rdata`; registered, held until the next response.
- `rsp_ready`  out  1  one-cycle response strobe to the crypto `mem_ready`.
- `rsp_err`  out  1  qualifies `rsp_ready`: 1 means out-of-range or misaligned.
- `cpu_busy`  in  1  CPU owns the SRAM port this cycle.
- `cpu_stall`  out  1  registered request for the CPU to yield the SRAM port.
- `sram_en`  out  1  SRAM read enable (combinational).
- `sram_addr`  out  AW  SRAM word address, driven from the captured request address.
- `sram_rdata`  in  32  SRAM read data, valid `RD_LATENCY` cycles after the `sram_en` edge.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ARB, WAIT, RESP, ERR, DONE.
- **IDLE**, when `req_valid` = 1:
  - Capture `req_addr`.
  - Check validity: `req_addr[1:0]` == 0, and the 33-bit unsigned offset `req_addr - ADDR_BASE` is < `ADDR_SIZE`. Negative offsets and wrap-around therefore fail the check.
  - Valid → ARB. Invalid → ERR.
- **ARB**:
  - `sram_en` = `!cpu_busy`.
  - `sram_addr` = offset[AW+1:2].
  - On issue (`sram_en` = 1): clear the starve counter and `cpu_stall`, then → WAIT.
  - While `cpu_busy` = 1: increment the starve counter (saturating). When it reaches `STARVE_LIMIT`, set `cpu_stall` = 1; it stays high until the read is issued.
  - If `req_valid` drops while in ARB: → IDLE with no response; clear the counter and `cpu_stall`.
- **WAIT**:
  - Count `RD_LATENCY` cycles.
  - On the last count, capture `sram_rdata` into `rsp_rdata`.
  - If `req_valid` = 1 at capture → RESP. Otherwise discard the data and → IDLE.
- **RESP**: `rsp_ready` = 1, `rsp_err` = 0 for exactly one cycle, then → DONE.
- **ERR**: `rsp_ready` = 1, `rsp_err` = 1, `rsp_rdata` = 0 for one cycle. No SRAM access. Then → DONE.
- **DONE**: wait for `req_valid` = 0, then → IDLE.
  - The initiator must deassert `req_valid` for at least one cycle between requests.
  - This prevents a request that is still held high from being serviced twice.
- `sram_en` is only ever high in ARB. `sram_en` and `cpu_busy` are never both high.

## Timing
- Reset values of all outputs: `rsp_rdata` = 0, `rsp_ready` = 0, `rsp_err` = 0, `cpu_stall` = 0, `sram_en` = 0, `busy` = 0. State = IDLE, counters = 0.
- Uncontended read: `req_valid` sampled at edge 0 → `sram_en` in cycle 1 → `rsp_ready` in cycle 2 + `RD_LATENCY`. With `RD_LATENCY` = 1 the strobe is in cycle 3.
- Each CPU-busy cycle in ARB adds one cycle of latency.
- `cpu_stall` rises in the cycle after the `STARVE_LIMIT`-th lost cycle.
- Error response: `rsp_ready` with `rsp_err` in cycle 1.
- Minimum request period is `RD_LATENCY` + 4 cycles: the response latency plus DONE plus the `req_valid` low cycle.
- Reset mid-operation: asynchronously returns to IDLE with all outputs at their reset values. Any pending SRAM data is ignored.

## Test plan
- **Plain read**: `RD_LATENCY` = 1, SRAM word 5 = 32'hDEADBEEF, `req_addr` = 32'h14, `cpu_busy` = 0 → `sram_en` in cycle 1 with `sram_addr` = 5; `rsp_ready` in cycle 3 with `rsp_rdata` = 32'hDEADBEEF and `rsp_err` = 0; `busy` is low after `req_valid` drops.
- **Errors**: `req_addr` = 32'h0001_0000, then 32'h2 → each gets `rsp_ready` = 1, `rsp_err` = 1, `rsp_rdata` = 0 in cycle 1; `sram_en` never asserts.
- **Contention and starvation**: `cpu_busy` held high with `STARVE_LIMIT` = 4 → `cpu_stall` = 1 after 4 lost cycles. Then drop `cpu_busy` → `sram_en` = 1 with `cpu_busy` = 0 in that cycle, `cpu_stall` clears on issue, and the response data is correct.
- **Abort**: drop `req_valid` during ARB, and separately during WAIT → no `rsp_ready` in either case; the next request is served normally.
- **Held valid**: keep `req_valid` high for 5 cycles after `rsp_ready` → exactly one response and no second `sram_en`.
- **Reset mid-WAIT**: assert `rst_n` = 0 during WAIT with `RD_LATENCY` = 4 → all outputs return to 0 immediately; after release, a new read of word 0 returns the correct data.
